// File: rtl/shift_module_pkg.sv
// rtl/shift_module_pkg.sv - shared widths and control encodings for shift_module
//
// Purpose : default operand/shift-amount widths and the named Type/Direction
//           encodings used by shift_module and its testbench.
// Ports   : none (package).
package shift_module_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;
    localparam logic TYPE_LOGICAL = 1'b0;
    localparam logic TYPE_ARITH   = 1'b1;

endpackage : shift_module_pkg

// File: rtl/shift_module_barrel_shift_core.sv
// rtl/shift_module_barrel_shift_core.sv - combinational log2(WIDTH)-stage barrel shifter
//
// Purpose : shifts data by amount, left (zero fill) or right (fill-bit fill).
// Ports   : data   [WIDTH-1:0]   operand
//           amount [SHAMT_W-1:0] unsigned shift distance
//           right                1 = shift right, 0 = shift left
//           fill                 bit shifted into vacated MSBs on a right shift
//           result [WIDTH-1:0]   shifted operand
module barrel_shift_core #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               right,
    input  logic               fill,
    output logic [WIDTH-1:0]   result
);

    // stage[k] is the operand after stages 0..k-1 have been applied.
    logic [WIDTH-1:0] stage [0:SHAMT_W];

    assign stage[0] = data;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 2 ** k;

        logic [WIDTH-1:0] fill_mask;
        logic [WIDTH-1:0] shifted;

        // Ones in the SH most-significant positions vacated by a right shift.
        assign fill_mask = ~({WIDTH{1'b1}} >> SH);
        assign shifted   = right ? ((stage[k] >> SH) | (fill ? fill_mask : '0))
                                 : (stage[k] << SH);
        assign stage[k+1] = amount[k] ? shifted : stage[k];
    end

    assign result = stage[SHAMT_W];

endmodule : barrel_shift_core

// File: rtl/shift_module.sv
// rtl/shift_module.sv - registered logical/arithmetic left/right shifter, 1-cycle latency
//
// Purpose : captures a shift request when in_valid is high and presents the
//           result on Output with a one-cycle out_valid pulse the next cycle.
// Ports   : clk, rst_n (async, active low)
//           in_valid                request strobe, no backpressure
//           Input        [WIDTH-1:0]   operand
//           Shift_Amount [SHAMT_W-1:0] unsigned distance
//           Type                    0 = logical, 1 = arithmetic
//           Direction               0 = left, 1 = right
//           Output       [WIDTH-1:0]   registered result, holds when idle
//           out_valid               high one cycle per captured request
module shift_module #(
    parameter int WIDTH   = shift_module_pkg::WIDTH,
    parameter int SHAMT_W = shift_module_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   Input,
    input  logic [SHAMT_W-1:0] Shift_Amount,
    input  logic               Type,
    input  logic               Direction,
    output logic [WIDTH-1:0]   Output,
    output logic               out_valid
);

    import shift_module_pkg::*;

    logic             right;
    logic             fill;
    logic [WIDTH-1:0] shift_result;

    assign right = (Direction == DIR_RIGHT);
    // Sign extension only for an arithmetic right shift; left shifts always zero-fill.
    assign fill  = (Type == TYPE_ARITH) & right & Input[WIDTH-1];

    barrel_shift_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .data   (Input),
        .amount (Shift_Amount),
        .right  (right),
        .fill   (fill),
        .result (shift_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Output    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Output <= shift_result;
            end
        end
    end

endmodule : shift_module

// File: tb/tb_shift_module.sv
// tb/tb_shift_module.sv - self-checking bench for shift_module
module tb_shift_module;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  Input;
    logic [SW-1:0] Shift_Amount;
    logic          Type;
    logic          Direction;
    logic [W-1:0]  Output;
    logic          out_valid;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] exp_out;

    shift_module #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .Input        (Input),
        .Shift_Amount (Shift_Amount),
        .Type         (Type),
        .Direction    (Direction),
        .Output       (Output),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    // Shift defined as multiplication / floor division by 2**n on 32-bit values.
    function automatic logic [W-1:0] model(logic [W-1:0] x, int n, logic t, logic d);
        longint p;
        longint ux;
        longint r;
        p  = longint'(1) << n;
        ux = longint'({32'b0, x});
        if (!d) begin
            r = (ux * p) % 64'sh1_0000_0000;
        end else if (t && x[W-1]) begin
            ux = ux - 64'sh1_0000_0000;
            r  = (ux - (p - 1)) / p;
        end else begin
            r = ux / p;
        end
        return r[W-1:0];
    endfunction

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the negedge, sample #1 after the following posedge.
    task automatic step(string tag, logic v, logic [W-1:0] x, int n, logic t, logic d);
        @(negedge clk);
        in_valid     = v;
        Input        = x;
        Shift_Amount = SW'(n);
        Type         = t;
        Direction    = d;
        @(posedge clk);
        #1;
        if (v) exp_out = model(x, n, t, d);
        check({tag, ".out"}, Output, exp_out);
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, v});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; Input = '0;
        Shift_Amount = '0; Type = 1'b0; Direction = 1'b0;
        exp_out = '0;
        #12;
        check("reset.out", Output, 32'h0);
        check("reset.vld", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step("idle0", 1'b0, 32'h0, 0, 1'b0, 1'b0);

        // Directed vectors; expected constants cross-checked against the model.
        step("ll23_5", 1'b1, 32'd23, 5, 1'b0, 1'b0);
        check("ll23_5.k", Output, 32'd736);
        step("lr23_5", 1'b1, 32'd23, 5, 1'b0, 1'b1);
        check("lr23_5.k", Output, 32'd0);
        step("ar23_5", 1'b1, 32'd23, 5, 1'b1, 1'b1);
        check("ar23_5.k", Output, 32'd0);
        step("al23_5", 1'b1, 32'd23, 5, 1'b1, 1'b0);
        check("al23_5.k", Output, 32'd736);
        step("al26_13", 1'b1, 32'd26, 13, 1'b1, 1'b0);
        check("al26_13.k", Output, 32'd212992);
        step("ar_msb4", 1'b1, 32'h8000_0000, 4, 1'b1, 1'b1);
        check("ar_msb4.k", Output, 32'hF800_0000);
        step("lr_msb4", 1'b1, 32'h8000_0000, 4, 1'b0, 1'b1);
        check("lr_msb4.k", Output, 32'h0800_0000);
        for (int c = 0; c < 4; c++) begin
            step($sformatf("zero%0d", c), 1'b1, 32'hA5A5_A5A5, 0, c[1], c[0]);
            check($sformatf("zero%0d.k", c), Output, 32'hA5A5_A5A5);
        end
        step("ll1_31", 1'b1, 32'h1, 31, 1'b0, 1'b0);
        check("ll1_31.k", Output, 32'h8000_0000);
        step("ar_ff31", 1'b1, 32'hFFFF_0000, 31, 1'b1, 1'b1);
        check("ar_ff31.k", Output, 32'hFFFF_FFFF);

        // Idle cycles hold the last result.
        step("hold0", 1'b0, 32'h1234_5678, 3, 1'b0, 1'b0);
        step("hold1", 1'b0, 32'h8765_4321, 7, 1'b1, 1'b1);

        // Randomized mix of back-to-back requests and idle gaps.
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rnd%0d", i), ($urandom_range(0, 4) != 0), $urandom,
                 $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        // Reset mid-stream with a request being presented.
        step("pre_rst", 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        in_valid = 1'b1;
        Input    = 32'h0000_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        exp_out = '0;
        check("rst_async.out", Output, 32'h0);
        check("rst_async.vld", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held.out", Output, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("post_rst%0d", i), 1'b0, 32'hFFFF_FFFF, 1, 1'b1, 1'b1);
        end
        step("first_after_rst", 1'b1, 32'hC000_0001, 1, 1'b1, 1'b1);
        check("first_after_rst.k", Output, 32'hE000_0000);
        step("tail", 1'b0, 32'h0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_shift_module
